// File: rtl/shift_arbiter_seq_pkg.sv
// Shared definitions for the shift arbiter: FSM states, shift direction and
// the layout of the operation latched at accept time.
package shift_arbiter_seq_pkg;

  localparam int OP_DATA_W = 8;
  localparam int OP_CNT_W  = 4;

  localparam logic DIR_R = 1'b1;
  localparam logic DIR_L = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                 id;
    logic                 rot;
    logic                 dir;
    logic [OP_CNT_W-1:0]  count;
    logic [OP_DATA_W-1:0] data;
  } op_t;

endpackage

// File: rtl/shift_arbiter_seq_barrel.sv
// Combinational 8-bit barrel shifter: logical shift or rotate by 0..7,
// carry is the last bit moved across the word boundary, z flags a zero result.
module shift_arbiter_seq_barrel
  import shift_arbiter_seq_pkg::*;
(
  input  logic [7:0] data,
  input  logic [2:0] bitcount,
  input  logic       dir,
  input  logic       rot,
  output logic [7:0] out,
  output logic       c,
  output logic       z
);

  logic [2:0] wrap_amt;

  always_comb begin
    // 8 - bitcount modulo 8; only used when bitcount is non-zero
    wrap_amt = 3'd0 - bitcount;
    out      = data;
    c        = 1'b0;
    if (bitcount != 3'd0) begin
      if (dir == DIR_R) begin
        out = data >> bitcount;
        if (rot) out = out | (data << wrap_amt);
        c = data[bitcount - 3'd1];
      end else begin
        out = data << bitcount;
        if (rot) out = out | (data >> wrap_amt);
        c = data[wrap_amt];
      end
    end
    z = (out == 8'd0);
  end

endmodule

// File: rtl/shift_arbiter_seq.sv
// Round-robin front end for one shared 8-bit barrel shifter; counts up to 15
// are served by running the shifter for one or two passes.
module shift_arbiter_seq
  import shift_arbiter_seq_pkg::*;
#(
  parameter int DATA_W   = OP_DATA_W,
  parameter int CNT_W    = OP_CNT_W,
  parameter bit RR_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [CNT_W-1:0]  req0_count,
  input  logic              req0_dir,
  input  logic              req0_rot,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [CNT_W-1:0]  req1_count,
  input  logic              req1_dir,
  input  logic              req1_rot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_c,
  output logic              rsp_z
);

  // Rotates wrap modulo 8; logical shifts saturate at 14 (anything >= 8 is zero).
  function automatic logic [OP_CNT_W-1:0] sat_count(input logic [OP_CNT_W-1:0] cnt,
                                                    input logic rot);
    if (rot) return {1'b0, cnt[2:0]};
    return (cnt > 4'd14) ? 4'd14 : cnt;
  endfunction

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  op_t              op_q, op_d;
  logic [7:0]       work_q, work_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_c_q, rsp_c_d;
  logic             rsp_z_q, rsp_z_d;

  logic             gnt0, gnt1;
  logic [2:0]       p1, p2;
  logic [7:0]       sh_data, sh_out;
  logic [2:0]       sh_cnt;
  logic             sh_c, sh_z;

  assign gnt0 = req0_valid && (!req1_valid || !rr_ptr_q);
  assign gnt1 = req1_valid && (!req0_valid ||  rr_ptr_q);

  assign req0_ready = (state_q == ST_IDLE) && gnt0;
  assign req1_ready = (state_q == ST_IDLE) && gnt1;

  assign p1 = (op_q.count > 4'd7) ? 3'd7 : op_q.count[2:0];
  assign p2 = 3'(op_q.count - {1'b0, p1});

  assign sh_data = (state_q == ST_PASS2) ? work_q : op_q.data;
  assign sh_cnt  = (state_q == ST_PASS2) ? p2     : p1;

  shift_arbiter_seq_barrel u_barrel (
    .data     (sh_data),
    .bitcount (sh_cnt),
    .dir      (op_q.dir),
    .rot      (op_q.rot),
    .out      (sh_out),
    .c        (sh_c),
    .z        (sh_z)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    work_d      = work_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_c_d     = rsp_c_q;
    rsp_z_d     = rsp_z_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          op_d.id    = gnt1;
          op_d.rot   = gnt1 ? req1_rot  : req0_rot;
          op_d.dir   = gnt1 ? req1_dir  : req0_dir;
          op_d.data  = gnt1 ? req1_data : req0_data;
          op_d.count = sat_count(gnt1 ? req1_count : req0_count, op_d.rot);
          rr_ptr_d   = ~gnt1;
          state_d    = ST_PASS1;
        end
      end
      ST_PASS1: begin
        work_d = sh_out;
        if (p2 != 3'd0) begin
          state_d = ST_PASS2;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = op_q.id;
          rsp_data_d  = sh_out;
          rsp_c_d     = sh_c;
          rsp_z_d     = sh_z;
          state_d     = ST_RESP;
        end
      end
      ST_PASS2: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = op_q.id;
        rsp_data_d  = sh_out;
        rsp_c_d     = sh_c;
        rsp_z_d     = sh_z;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= RR_RESET;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_c_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_c_q     <= rsp_c_d;
      rsp_z_q     <= rsp_z_d;
    end
  end

  // Operand and intermediate result are only read under FSM control.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    work_q <= work_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// Directed bench for shift_arbiter_seq: vector table of single operations plus
// hand-written contention, back-pressure and mid-operation reset sequences.
module tb_shift_arbiter_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_dir, req0_rot;
  logic [7:0] req0_data;
  logic [3:0] req0_count;
  logic       req1_valid, req1_ready, req1_dir, req1_rot;
  logic [7:0] req1_data;
  logic [3:0] req1_count;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_c, rsp_z;
  logic [7:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_arbiter_seq #(.DATA_W(8), .CNT_W(4), .RR_RESET(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_count (req0_count),
    .req0_dir   (req0_dir),
    .req0_rot   (req0_rot),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_count (req1_count),
    .req1_dir   (req1_dir),
    .req1_rot   (req1_rot),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_c      (rsp_c),
    .rsp_z      (rsp_z)
  );

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic [3:0] cnt;
    logic       dir;
    logic       rot;
    logic [7:0] ed;
    logic       ec;
    logic       ez;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [7:0] d, input logic [3:0] c,
                       input logic dir, input logic rot);
    if (!sel) begin
      req0_valid = 1'b1; req0_data = d; req0_count = c; req0_dir = dir; req0_rot = rot;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_count = c; req1_dir = dir; req1_rot = rot;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         lat;
    logic [7:0] held;
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(v.sel, v.data, v.cnt, v.dir, v.rot);
    #1;
    chk($sformatf("v%0d_ready", idx), v.sel ? req1_ready : req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_lat", idx), lat, v.lat);
    chk($sformatf("v%0d_id", idx), rsp_id, v.sel);
    chk($sformatf("v%0d_data", idx), rsp_data, v.ed);
    chk($sformatf("v%0d_c", idx), rsp_c, v.ec);
    chk($sformatf("v%0d_z", idx), rsp_z, v.ez);
    held = rsp_data;
    @(negedge clk);
    chk($sformatf("v%0d_hold", idx), {rsp_valid, rsp_data}, {1'b1, held});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_drop", idx), rsp_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int         ids[$];
    int         cyc[$];
    logic [7:0] held;
    logic       seen;

    //          sel   data   cnt   dir   rot   exp    c     z     lat
    vecs[0]  = '{1'b0, 8'hAF, 4'd1,  1'b1, 1'b1, 8'hD7, 1'b1, 1'b0, 2};
    vecs[1]  = '{1'b1, 8'hAF, 4'd2,  1'b1, 1'b0, 8'h2B, 1'b1, 1'b0, 2};
    vecs[2]  = '{1'b1, 8'hAF, 4'd0,  1'b1, 1'b0, 8'hAF, 1'b0, 1'b0, 2};
    vecs[3]  = '{1'b0, 8'h01, 4'd8,  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3};
    vecs[4]  = '{1'b1, 8'hAF, 4'd9,  1'b1, 1'b1, 8'hD7, 1'b1, 1'b0, 2};
    vecs[5]  = '{1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2};
    vecs[6]  = '{1'b0, 8'h81, 4'd15, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3};
    vecs[7]  = '{1'b1, 8'h96, 4'd3,  1'b0, 1'b1, 8'hB4, 1'b0, 1'b0, 2};
    vecs[8]  = '{1'b0, 8'h96, 4'd12, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3};
    vecs[9]  = '{1'b1, 8'h80, 4'd8,  1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3};
    vecs[10] = '{1'b0, 8'h0F, 4'd11, 1'b0, 1'b1, 8'h78, 1'b0, 1'b0, 2};
    vecs[11] = '{1'b1, 8'h3C, 4'd7,  1'b1, 1'b1, 8'h78, 1'b0, 1'b0, 2};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_count = '0; req0_dir = 1'b0; req0_rot = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_count = '0; req1_dir = 1'b0; req1_rot = 1'b0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_data, rsp_c, rsp_z}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Contention: both requesters valid, consumer always ready
    do_reset();
    @(negedge clk);
    drive(1'b0, 8'hAF, 4'd1, 1'b1, 1'b1);
    drive(1'b1, 8'hAF, 4'd2, 1'b1, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids.push_back(int'(rsp_id));
        cyc.push_back(i);
        chk($sformatf("cont_data%0d", i), rsp_data, rsp_id ? 8'h2B : 8'hD7);
      end
    end
    chk("cont_count", (ids.size() >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4; k++) begin
      if (k < ids.size()) chk($sformatf("cont_id%0d", k), ids[k], k % 2);
      if (k + 1 < cyc.size()) chk($sformatf("cont_gap%0d", k), cyc[k+1] - cyc[k], 3);
    end

    // Back-pressure on a pending response
    rsp_ready = 1'b0;
    held = rsp_data;
    seen = rsp_id;
    chk("stall_start", rsp_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall_rsp%0d", i), {rsp_valid, rsp_id, rsp_data}, {1'b1, seen, held});
      chk($sformatf("stall_gnt%0d", i), {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", rsp_valid, 0);
    chk("stall_next_gnt", {req0_ready, req1_ready}, seen ? 2'b10 : 2'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;

    // Reset while the second pass of an operation is in progress
    do_reset();
    @(negedge clk);
    drive(1'b0, 8'h01, 4'd8, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'h11, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 4'd1, 1'b0, 1'b0);
    #1;
    chk("mid_rst_rrptr", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_rst_dropped", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
